// File: rtl/aes256_key_expand_pkg.sv
// Shared AES definitions: round counts, FSM encoding and the key-schedule Rcon table.
package aes_pkg;

    localparam int AES256_NR  = 14;
    localparam int AES_NUM_RK = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // AES-256 only ever needs Rcon[1..7]; index 0 is unused.
    function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
        case (idx)
            3'd1:    aes_rcon = 8'h01;
            3'd2:    aes_rcon = 8'h02;
            3'd3:    aes_rcon = 8'h04;
            3'd4:    aes_rcon = 8'h08;
            3'd5:    aes_rcon = 8'h10;
            3'd6:    aes_rcon = 8'h20;
            3'd7:    aes_rcon = 8'h40;
            default: aes_rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes256_key_expand_if.sv
// Key-load request and round-key bank bus between a key source and the expansion engine.
interface aes256_key_expand_if;

    logic [0:255]  key_in;
    logic          key_load;
    logic          busy;
    logic          keys_valid;
    logic [0:1919] round_keys;

    modport master (
        output key_in,
        output key_load,
        input  busy,
        input  keys_valid,
        input  round_keys
    );

    modport slave (
        input  key_in,
        input  key_load,
        output busy,
        output keys_valid,
        output round_keys
    );

endinterface

// File: rtl/aes256_key_expand_sbox.sv
// Combinational AES forward S-box; byte 0x00 maps from the most significant byte of the table.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a sits (255-a) bytes above the LSB; ~a equals 255-a for a byte.
    logic [10:0] w_base;

    assign w_base = {~i_a, 3'b000};
    assign o_y    = SBOX_FLAT[w_base +: 8];

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: loads rk0/rk1 from the key, then derives one round key per cycle.
module aes256_key_expand
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    aes256_key_expand_if.slave bus
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_load;
    logic [3:0]   r_rnd;
    logic [127:0] r_rk [AES_NUM_RK];

    logic [3:0]   w_pi;
    logic [3:0]   w_qi;
    logic [31:0]  w_p;
    logic [127:0] w_q;
    logic [31:0]  w_sb_in;
    logic [31:0]  w_sb_out;
    logic [31:0]  w_t;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.key_load) begin
                    w_state_nxt = ST_EXPAND;
                    w_load      = 1'b1;
                end
            end
            ST_EXPAND: begin
                if (r_rnd == 4'(AES256_NR)) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Clamp keeps the read indices in range outside EXPAND, where the result is unused.
    assign w_pi = (r_rnd > 4'd1) ? r_rnd - 4'd1 : 4'd0;
    assign w_qi = (r_rnd > 4'd1) ? r_rnd - 4'd2 : 4'd0;
    assign w_p  = r_rk[w_pi][31:0];
    assign w_q  = r_rk[w_qi];

    assign w_sb_in = r_rnd[0] ? w_p : {w_p[23:0], w_p[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_a (w_sb_in[8*g +: 8]),
            .o_y (w_sb_out[8*g +: 8])
        );
    end

    assign w_t  = w_sb_out ^ (r_rnd[0] ? 32'h0 : {aes_rcon(r_rnd[3:1]), 24'h0});
    assign w_w0 = w_q[127:96] ^ w_t;
    assign w_w1 = w_q[95:64]  ^ w_w0;
    assign w_w2 = w_q[63:32]  ^ w_w1;
    assign w_w3 = w_q[31:0]   ^ w_w2;

    // NOTE: the key bank is a register array with a real reset so round_keys reads all-zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rnd <= '0;
            for (int k = 0; k < AES_NUM_RK; k++) r_rk[k] <= '0;
        end else if (w_load) begin
            r_rk[0] <= bus.key_in[0:127];
            r_rk[1] <= bus.key_in[128:255];
            r_rnd   <= 4'd2;
        end else if (r_state == ST_EXPAND) begin
            r_rk[r_rnd] <= {w_w0, w_w1, w_w2, w_w3};
            r_rnd       <= r_rnd + 4'd1;
        end
    end

    assign bus.busy       = (r_state == ST_EXPAND);
    assign bus.keys_valid = (r_state == ST_DONE);

    for (genvar g = 0; g < AES_NUM_RK; g++) begin : g_flat
        assign bus.round_keys[128*g +: 128] = r_rk[g];
    end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench: word-level FIPS-197 key expansion model with an S-box derived from GF(2^8) inversion.
module tb_aes256_key_expand;
    import aes_pkg::*;

    typedef logic [14:0][127:0] rk_pack_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [7:0] sb [256];
    rk_pack_t   exp_rk;
    logic       mon_en;

    aes256_key_expand_if kx ();

    aes256_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Standard 60-word expansion: w[i] = w[i-8] ^ temp, transformed every 4th word.
    function automatic rk_pack_t model_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_pack_t    r;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    function automatic logic [127:0] dut_rk(input int j);
        return kx.round_keys[128*j +: 128];
    endfunction

    // Continuous compare: valid keys must equal the model and busy/valid are exclusive.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("busy_and_valid", 128'(kx.busy & kx.keys_valid), 128'(1'b0));
            if (kx.keys_valid) begin
                for (int j = 0; j < AES_NUM_RK; j++)
                    check($sformatf("mon_rk%0d", j), dut_rk(j), exp_rk[j]);
            end
        end
    end

    task automatic run_expand(input logic [255:0] key, input int glitch_at, input logic [255:0] gkey);
        rk_pack_t m;
        int       busy_cnt;
        m = model_expand(key);
        @(negedge clk);
        kx.key_in   = key;
        kx.key_load = 1'b1;
        @(posedge clk);
        exp_rk = m;
        @(negedge clk);
        kx.key_load = 1'b0;
        busy_cnt = 0;
        check("load_rk0", dut_rk(0), key[255:128]);
        check("load_rk1", dut_rk(1), key[127:0]);
        check("load_valid_low", 128'(kx.keys_valid), 128'(1'b0));
        if (kx.busy) busy_cnt++;
        for (int e = 1; e <= 13; e++) begin
            if (e - 1 == glitch_at) begin
                kx.key_in   = gkey;
                kx.key_load = 1'b1;
            end
            @(negedge clk);
            kx.key_load = 1'b0;
            check($sformatf("prog_rk%0d", e + 1), dut_rk(e + 1), m[e + 1]);
            check($sformatf("valid_at_L+%0d", e), 128'(kx.keys_valid), 128'(e == 13));
            if (kx.busy) busy_cnt++;
        end
        check("busy_cycles", 128'(busy_cnt), 128'd13);
    endtask

    localparam logic [255:0] FIPS_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        rk_pack_t     m;
        logic [255:0] ka;
        logic [255:0] kb;
        logic [7:0]   inv;

        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        exp_rk = '0;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        reset       = 1'b1;
        kx.key_in   = '0;
        kx.key_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(kx.busy), 128'(1'b0));
        check("rst_valid", 128'(kx.keys_valid), 128'(1'b0));
        for (int j = 0; j < AES_NUM_RK; j++) check($sformatf("rst_rk%0d", j), dut_rk(j), 128'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        m = model_expand(FIPS_KEY);
        check("model_fips_rk2", m[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        check("model_fips_rk14", m[14], 128'hfe4890d1e6188d0b046df344706c631e);
        m = model_expand(256'h0);
        check("model_zero_rk2", m[2], 128'h62636363626363636263636362636363);
        check("model_zero_rk3", m[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

        run_expand(FIPS_KEY, -1, '0);
        check("fips_valid", 128'(kx.keys_valid), 128'(1'b1));
        check("fips_rk2", dut_rk(2), 128'h9ba354118e6925afa51a8b5f2067fcde);
        check("fips_rk14", dut_rk(14), 128'hfe4890d1e6188d0b046df344706c631e);

        // Reload from DONE with the all-zero key.
        run_expand(256'h0, -1, '0);
        check("zero_rk2", dut_rk(2), 128'h62636363626363636263636362636363);
        check("zero_rk3", dut_rk(3), 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

        ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_expand(ka, 5, kb);
        repeat (3) @(negedge clk);
        check("glitch_rk0", dut_rk(0), ka[255:128]);
        check("glitch_busy", 128'(kx.busy), 128'(1'b0));

        // Asynchronous reset in the middle of an expansion.
        @(negedge clk);
        kx.key_in   = kb;
        kx.key_load = 1'b1;
        @(negedge clk);
        kx.key_load = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 128'(kx.busy), 128'(1'b0));
        check("arst_valid", 128'(kx.keys_valid), 128'(1'b0));
        for (int j = 0; j < AES_NUM_RK; j++) check($sformatf("arst_rk%0d", j), dut_rk(j), 128'h0);
        @(negedge clk);
        reset = 1'b0;
        run_expand(kb, -1, '0);

        for (int it = 0; it < 50; it++) begin
            ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_expand(ka, -1, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
